// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply and
// restoring divide, one bit per cycle, with a stall that holds the front of the pipeline.
module ex_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            valid_i,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   state_t            r_state;
   op_t               r_op;
   logic              r_neg;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_opb;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   // Operand decode and capture values
   op_t               w_op;
   logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_sign;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic              w_div_zero, w_ovf, w_fast;
   logic [XLEN-1:0]   w_fast_res;

   assign w_op       = op_t'(funct3);
   assign w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
   assign w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
   assign w_a_neg    = w_a_signed && rs1[XLEN-1];
   assign w_b_neg    = w_b_signed && rs2[XLEN-1];
   assign w_a_mag    = w_a_neg ? -rs1 : rs1;
   assign w_b_mag    = w_b_neg ? -rs2 : rs2;
   assign w_div_zero = funct3[2] && (rs2 == '0);
   assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) && (rs1 == MIN_NEG) && (rs2 == '1);
   assign w_fast     = w_div_zero || w_ovf;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_sign = 1'b0;
      case (w_op)
         OP_MULH, OP_DIV:   w_sign = w_a_neg ^ w_b_neg;
         OP_MULHSU, OP_REM: w_sign = w_a_neg;
         default:           w_sign = 1'b0;
      endcase
   end

   always_comb begin
      w_fast_res = '0;
      if (w_div_zero)  w_fast_res = funct3[1] ? rs1 : '1;
      else if (w_ovf)  w_fast_res = funct3[1] ? '0 : MIN_NEG;
   end

   // One iteration: r_hi/r_lo is the product register for multiply, {rem, quot} for divide
   logic [XLEN:0]     w_add;
   logic [2*XLEN-1:0] w_mul_next;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN-1:0]   w_diff;
   logic              w_ge;
   logic [XLEN-1:0]   w_div_hi, w_div_lo, w_hi_next, w_lo_next;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_calc_res;

   assign w_add      = {1'b0, r_hi} + {1'b0, r_opb};
   assign w_mul_next = r_lo[0] ? {w_add, r_lo[XLEN-1:1]} : {1'b0, r_hi, r_lo[XLEN-1:1]};
   assign w_rem_sh   = {r_hi, r_lo[XLEN-1]};
   assign w_ge       = w_rem_sh >= {1'b0, r_opb};
   assign w_diff     = w_rem_sh[XLEN-1:0] - r_opb;
   assign w_div_hi   = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
   assign w_div_lo   = {r_lo[XLEN-2:0], w_ge};
   assign w_hi_next  = r_op[2] ? w_div_hi : w_mul_next[2*XLEN-1:XLEN];
   assign w_lo_next  = r_op[2] ? w_div_lo : w_mul_next[XLEN-1:0];
   assign w_prod_fix = r_neg ? -{w_hi_next, w_lo_next} : {w_hi_next, w_lo_next};

   always_comb begin
      w_calc_res = '0;
      case (r_op)
         OP_MUL:                      w_calc_res = w_prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             w_calc_res = r_neg ? -w_div_lo : w_div_lo;
         default:                     w_calc_res = r_neg ? -w_div_hi : w_div_hi;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      if (!rst && !flush) begin
         case (r_state)
            IDLE:    stall = valid_i;
            CALC:    stall = 1'b1;
            default: stall = 1'b0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_op     <= OP_MUL;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opb    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else if (flush) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (valid_i) begin
                  r_op  <= w_op;
                  r_neg <= w_sign;
                  r_hi  <= '0;
                  r_lo  <= funct3[2] ? w_a_mag : w_b_mag;
                  r_opb <= funct3[2] ? w_b_mag : w_a_mag;
                  if (w_fast) begin
                     r_result <= w_fast_res;
                     r_done   <= 1'b1;
                     r_state  <= DONE;
                  end else begin
                     r_cnt   <= CW'(XLEN);
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_hi  <= w_hi_next;
               r_lo  <= w_lo_next;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_result <= w_calc_res;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: results, latency, fast paths, flush, reset and back-to-back ops.
module tb_ex_muldiv;
   logic        clk = 1'b0;
   logic        rst, flush, valid_i;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        stall, done;
   logic [31:0] result;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   always #5 clk = ~clk;

   ex_muldiv #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .valid_i(valid_i),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   // Presents one op starting at the next falling edge and observes it until done (bounded).
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output int done_cyc, output logic [31:0] res);
      n_stall  = 0;
      done_cyc = 0;
      res      = 'x;
      @(negedge clk);
      valid_i = 1'b1; funct3 = f; rs1 = a; rs2 = b;
      for (int c = 1; c <= 60; c++) begin
         #1;
         if (stall) n_stall++;
         if (done) begin
            done_cyc = c;
            res      = result;
            break;
         end
         @(negedge clk);
      end
      valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; valid_i = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if ({stall, done, result} !== 34'd0) begin
         n_err++;
         $display("FAIL reset_outputs: stall=%b done=%b result=%h required all zero", stall, done, result);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         n_vec++;
         if (stall !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: stall=%b done=%b required 0 0", stall, done);
         end
      end
   endtask

   task automatic test_mul();
      vec_t v [7];
      int ns, dc;
      logic [31:0] res;
      v = '{'{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF},
            '{3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780},
            '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE}};
      for (int i = 0; i < 7; i++) begin
         do_op(v[i].f, v[i].a, v[i].b, ns, dc, res);
         n_vec++;
         if (res !== v[i].r) begin
            n_err++;
            $display("FAIL mul[%0d] f=%b result=%h required %h", i, v[i].f, res, v[i].r);
         end
         n_vec++;
         if (ns != 33 || dc != 34) begin
            n_err++;
            $display("FAIL mul_latency[%0d]: stall_cycles=%0d done_cycle=%0d required 33 34", i, ns, dc);
         end
      end
   endtask

   task automatic test_div();
      vec_t v [9];
      int ns, dc;
      logic [31:0] res;
      v = '{'{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
            '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
            '{3'b101, 32'd100,       32'd7,         32'd14},
            '{3'b111, 32'd100,       32'd7,         32'd2},
            '{3'b100, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD},
            '{3'b110, 32'd20,        32'hFFFF_FFFA, 32'd2},
            '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF},
            '{3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1},
            '{3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE}};
      for (int i = 0; i < 9; i++) begin
         do_op(v[i].f, v[i].a, v[i].b, ns, dc, res);
         n_vec++;
         if (res !== v[i].r) begin
            n_err++;
            $display("FAIL div[%0d] f=%b result=%h required %h", i, v[i].f, res, v[i].r);
         end
         n_vec++;
         if (ns != 33 || dc != 34) begin
            n_err++;
            $display("FAIL div_latency[%0d]: stall_cycles=%0d done_cycle=%0d required 33 34", i, ns, dc);
         end
      end
      repeat (5) @(negedge clk);
      #1;
      n_vec++;
      if (result !== 32'h7FFF_FFFE || done !== 1'b0) begin
         n_err++;
         $display("FAIL result_hold: result=%h done=%b required 7ffffffe 0", result, done);
      end
   endtask

   task automatic test_fast_path();
      vec_t v [6];
      int ns, dc;
      logic [31:0] res;
      v = '{'{3'b110, 32'd5,         32'd0,         32'd5},
            '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
            '{3'b111, 32'd7,         32'd0,         32'd7},
            '{3'b100, 32'hFFFF_FFFD, 32'd0,         32'hFFFF_FFFF},
            '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF}};
      for (int i = 0; i < 6; i++) begin
         do_op(v[i].f, v[i].a, v[i].b, ns, dc, res);
         n_vec++;
         if (res !== v[i].r) begin
            n_err++;
            $display("FAIL fast[%0d] f=%b result=%h required %h", i, v[i].f, res, v[i].r);
         end
         n_vec++;
         if (ns != 1 || dc != 2) begin
            n_err++;
            $display("FAIL fast_latency[%0d]: stall_cycles=%0d done_cycle=%0d required 1 2", i, ns, dc);
         end
      end
   endtask

   task automatic test_flush();
      int n_done, ns, dc;
      logic [31:0] res;
      @(negedge clk);
      valid_i = 1'b1; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
      repeat (10) @(negedge clk);
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
         n_err++;
         $display("FAIL flush_pre: stall=%b required 1", stall);
      end
      flush = 1'b1; valid_i = 1'b0;
      #1;
      n_vec++;
      if (stall !== 1'b0) begin
         n_err++;
         $display("FAIL flush_stall: stall=%b required 0", stall);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_vec++;
      // Last completed op before the flush was DIVU 5/0
      if (stall !== 1'b0 || done !== 1'b0 || result !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL flush_after: stall=%b done=%b result=%h required 0 0 ffffffff", stall, done, result);
      end
      n_done = 0;
      repeat (40) begin
         @(negedge clk); #1;
         if (done) n_done++;
      end
      n_vec++;
      if (n_done != 0) begin
         n_err++;
         $display("FAIL flush_no_done: done_pulses=%0d required 0", n_done);
      end
      do_op(3'b000, 32'd3, 32'd4, ns, dc, res);
      n_vec++;
      if (res !== 32'd12 || ns != 33 || dc != 34) begin
         n_err++;
         $display("FAIL flush_next_mul: result=%h stall=%0d done_cycle=%0d required 0000000c 33 34", res, ns, dc);
      end
   endtask

   task automatic test_rst_mid();
      int n_done;
      @(negedge clk);
      valid_i = 1'b1; funct3 = 3'b000; rs1 = 32'hFFFF; rs2 = 32'hFFFF;
      repeat (5) @(negedge clk);
      rst = 1'b1; valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if ({stall, done, result} !== 34'd0) begin
         n_err++;
         $display("FAIL rst_mid: stall=%b done=%b result=%h required all zero", stall, done, result);
      end
      n_done = 0;
      repeat (40) begin
         @(negedge clk); #1;
         if (done) n_done++;
      end
      n_vec++;
      if (n_done != 0) begin
         n_err++;
         $display("FAIL rst_mid_no_done: done_pulses=%0d required 0", n_done);
      end
   endtask

   task automatic test_back_to_back();
      int dc [2];
      logic [31:0] rr [2];
      int nd;
      dc = '{0, 0};
      rr = '{32'd0, 32'd0};
      nd = 0;
      @(negedge clk);
      valid_i = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6;
      for (int c = 1; c <= 80; c++) begin
         #1;
         if (done) begin
            if (nd < 2) begin
               dc[nd] = c;
               rr[nd] = result;
            end
            nd++;
            if (nd == 1) begin
               rs1 = 32'd9; rs2 = 32'd9;
            end else begin
               valid_i = 1'b0;
            end
         end
         @(negedge clk);
      end
      valid_i = 1'b0;
      n_vec++;
      if (nd != 2) begin
         n_err++;
         $display("FAIL b2b_count: done_pulses=%0d required 2", nd);
      end
      n_vec++;
      if (dc[0] != 34 || dc[1] - dc[0] != 34) begin
         n_err++;
         $display("FAIL b2b_timing: first=%0d gap=%0d required 34 34", dc[0], dc[1] - dc[0]);
      end
      n_vec++;
      if (rr[0] !== 32'd30 || rr[1] !== 32'd81) begin
         n_err++;
         $display("FAIL b2b_results: %h %h required 0000001e 00000051", rr[0], rr[1]);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_fast_path();
      test_flush();
      test_rst_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded funct3 and the rs1/rs2 operand values held in ID/EX.
- Produces a 32-bit result for the EX/MEM register.
- Drives a stall that holds the front of the pipeline until the result is ready.

Parameters:
- XLEN, 32, operand and result width in bits.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous kill of the in-flight operation (branch/exception).
- valid_i  input  1  ID/EX holds an M-extension instruction.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A, dividend for divide ops.
- rs2  input  XLEN  operand B, divisor for divide ops.
- stall  output  1  hold IF/ID and ID/EX (drive their en low) and insert a bubble into EX/MEM.
- done  output  1  one-cycle pulse; result is valid this cycle.
- result  output  XLEN  operation result.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, stall=0, done=0, result=0, counter=0, accumulators=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - stall = valid_i (combinational) and operands are captured when valid_i=1.
  - Fast path (divide op with rs2==0, or DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF) -> DONE.
  - Otherwise -> CALC, counter=XLEN.
- Operand capture:
  - Signed operands are converted to magnitudes; the result sign is recorded.
  - MULH: sign(rs1)^sign(rs2). MULHSU: sign(rs1) only. DIV: sign(rs1)^sign(rs2). REM: sign(rs1).
  - Unsigned ops record a positive sign.
- CALC:
  - stall=1, one iteration per cycle, counter decrements each cycle; at counter==1 -> DONE.
  - Multiply: shift-add over a 2*XLEN product register.
  - Divide: restoring algorithm. Shift {rem,quot} left 1; if rem>=divisor, subtract and set quotient bit 0.
- DONE:
  - stall=0, done=1, result registered; -> IDLE next cycle unconditionally.
  - valid_i is ignored in DONE; the same instruction is still visible while ID/EX advances.
- Result select:
  - MUL: low XLEN bits of the signed-corrected product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - Sign correction is a two's-complement negate of the full 2*XLEN product.
  - DIV/DIVU: quotient. REM/REMU: remainder. Quotient and remainder are negated when the recorded sign is negative.
- Fast-path results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=rs1 (signed and unsigned).
  - Signed overflow: quotient=0x80000000, remainder=0.
- Latency:
  - Normal ops: stall high for XLEN+1 cycles (IDLE accept + 32 CALC), done in cycle XLEN+2 after valid_i rises.
  - Fast path: stall high 1 cycle, done in cycle 2.
- Priority: rst > flush > state logic.
- flush in any state:
  - Next cycle state=IDLE, stall=0 combinationally in the flush cycle, done=0.
  - No done pulse for the killed op; result holds its last value.
- Back-to-back M ops: the second op is accepted in the cycle after DONE (IDLE with valid_i=1). No cycle is lost beyond the DONE cycle.
- result holds its value between done pulses.
- stall never asserts while valid_i=0 in IDLE.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> stall 33 cycles, then done=1 with result=0xFFFFFFEB.
- MULH rs1=rs2=0x80000000 -> result=0x40000000. MULHU rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 -> result=0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFD. REM with the same operands -> result=0xFFFFFFFF. DIVU rs1=100, rs2=7 -> result=14. REMU with the same operands -> result=2.
- DIVU 5/0 -> result=0xFFFFFFFF. REM 5/0 -> result=5. DIV 0x80000000/0xFFFFFFFF -> result=0x80000000. REM with the same operands -> result=0. All four: stall exactly 1 cycle, done in cycle 2.
- DIV started, flush pulsed in CALC cycle 10 -> stall=0 in that cycle, IDLE next cycle, no done pulse. A following MUL 3*4 completes normally with result=12.
- rst asserted mid-CALC -> all outputs 0 next cycle.
- Two MUL ops back to back (valid_i held through DONE) -> exactly two done pulses, separated by 34 cycles.
